// File: rtl/tick_gen_pkg.sv
// tick_gen_pkg: shared mode encodings and default sizing for the tick generator
package tick_gen_pkg;
  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT = 1'b1;
  localparam int CNT_WDTH_DEF = 30;
  localparam int unsigned DEFAULT_PERIOD = 3_124_999;
endpackage

// File: rtl/tick_chan.sv
// tick_chan: one tick channel (period reg, counter, busy, tick, mode history); in: en/mode/start/load/load_val, out: tick/busy
module tick_chan
  import tick_gen_pkg::*;
#(
  parameter int CNT_WDTH = CNT_WDTH_DEF,
  parameter logic [CNT_WDTH-1:0] RST_PERIOD = CNT_WDTH'(tick_gen_pkg::DEFAULT_PERIOD)
) (
  input  logic                dclk,
  input  logic                rst,
  input  logic                en,
  input  logic                mode,
  input  logic                start,
  input  logic                load,
  input  logic [CNT_WDTH-1:0] load_val,
  output logic                tick,
  output logic                busy
);
  logic [CNT_WDTH-1:0] cnt, cnt_n, period, period_n;
  logic busy_n, tick_n, mode_q, term;
  assign term = cnt == period;
  always_comb begin
    cnt_n = cnt;
    period_n = period;
    busy_n = busy;
    tick_n = 1'b0;
    if (load) begin
      period_n = load_val;
      cnt_n = '0;
      busy_n = 1'b0;
    end else if (mode != mode_q) begin
      cnt_n = '0;
      busy_n = 1'b0;
    end else if (en) begin
      if (mode == MODE_PERIODIC) begin
        busy_n = 1'b0;
        cnt_n = term ? '0 : cnt + 1'b1;
        tick_n = term;
      end else if (start) begin
        cnt_n = '0;
        busy_n = 1'b1;
      end else if (busy) begin
        cnt_n = term ? '0 : cnt + 1'b1;
        busy_n = !term;
        tick_n = term;
      end else begin
        cnt_n = '0;
      end
    end
  end
  always_ff @(posedge dclk) begin
    if (rst) begin
      cnt <= '0;
      period <= RST_PERIOD;
      busy <= 1'b0;
      tick <= 1'b0;
      mode_q <= MODE_PERIODIC;
    end else begin
      cnt <= cnt_n;
      period <= period_n;
      busy <= busy_n;
      tick <= tick_n;
      mode_q <= mode;
    end
  end
endmodule

// File: rtl/tick_gen_multi.sv
// tick_gen_multi: NUM_CH programmable tick channels; load/load_ch/load_val write one period, en/mode/start per channel, tick/busy per channel
module tick_gen_multi #(
  parameter int NUM_CH = 4,
  parameter int CNT_WDTH = tick_gen_pkg::CNT_WDTH_DEF,
  parameter int unsigned DEFAULT_PERIOD = tick_gen_pkg::DEFAULT_PERIOD,
  parameter int LOG2_CH = 2
) (
  input  logic                dclk,
  input  logic                rst,
  input  logic [NUM_CH-1:0]   en,
  input  logic [NUM_CH-1:0]   mode,
  input  logic [NUM_CH-1:0]   start,
  input  logic                load,
  input  logic [LOG2_CH-1:0]  load_ch,
  input  logic [CNT_WDTH-1:0] load_val,
  output logic [NUM_CH-1:0]   tick,
  output logic [NUM_CH-1:0]   busy
);
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    tick_chan #(
      .CNT_WDTH(CNT_WDTH),
      .RST_PERIOD(CNT_WDTH'(DEFAULT_PERIOD))
    ) u_chan (
      .dclk(dclk),
      .rst(rst),
      .en(en[i]),
      .mode(mode[i]),
      .start(start[i]),
      .load(load && load_ch == LOG2_CH'(i)),
      .load_val(load_val),
      .tick(tick[i]),
      .busy(busy[i])
    );
  end
endmodule

// File: tb/tb_tick_gen_multi.sv
// tb_tick_gen_multi: scoreboard bench for tick_gen_multi with directed vectors
module tb_tick_gen_multi;
  logic dclk = 1'b0, rst = 1'b1, load = 1'b0;
  logic [3:0] en = '0, mode = '0, start = '0, tick, busy;
  logic [2:0] load_ch = '0;
  logic [7:0] load_val = '0;
  int cyc = 0, npass = 0, ntot = 0;
  typedef struct {
    int cyc;
    logic [3:0] t;
    logic [3:0] b;
    string nm;
  } exp_t;
  exp_t q[$];
  exp_t e;
  tick_gen_multi #(.NUM_CH(4), .CNT_WDTH(8), .DEFAULT_PERIOD(3), .LOG2_CH(3)) dut (
    .dclk(dclk), .rst(rst), .en(en), .mode(mode), .start(start), .load(load),
    .load_ch(load_ch), .load_val(load_val), .tick(tick), .busy(busy)
  );
  always #5 dclk = ~dclk;
  always @(posedge dclk) cyc <= cyc + 1;
  always @(negedge dclk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      ntot++;
      if (e.cyc == cyc && tick === e.t && busy === e.b) npass++;
      else $display("FAIL %s cyc=%0d tick=%b busy=%b expected tick=%b busy=%b", e.nm, cyc, tick, busy, e.t, e.b);
    end
  end
  task automatic cyc1(input logic [3:0] et, input logic [3:0] eb, input string nm);
    q.push_back('{cyc + 1, et, eb, nm});
    @(posedge dclk);
    #1;
    start = '0;
    load = 1'b0;
  endtask
  task automatic do_rst();
    rst = 1'b1;
    en = '0;
    mode = '0;
    cyc1(4'b0, 4'b0, "reset");
    rst = 1'b0;
  endtask
  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  initial begin
    @(posedge dclk);
    #1;
    do_rst();
    en = 4'b0001;
    for (int i = 0; i < 12; i++) cyc1((i % 4 == 3) ? 4'b0001 : 4'b0000, 4'b0, "per0");
    do_rst();
    en = 4'b0110;
    for (int k = 0; k < 9; k++) begin
      if (k == 0 || k == 5) begin
        load = 1'b1;
        load_ch = (k == 0) ? 3'd2 : 3'd5;
        load_val = (k == 0) ? 8'd0 : 8'd9;
      end
      cyc1((k == 0) ? 4'b0000 : (k % 4 == 3) ? 4'b0110 : 4'b0100, 4'b0, k == 5 ? "ld_bad_ch" : "ld_zero");
    end
    do_rst();
    mode = 4'b0010;
    cyc1(4'b0, 4'b0, "os_mchg");
    start = 4'b0010;
    cyc1(4'b0, 4'b0, "os_st_en0");
    en = 4'b0010;
    cyc1(4'b0, 4'b0, "os_idle0");
    start = 4'b0010;
    cyc1(4'b0, 4'b0010, "os_start");
    repeat (3) cyc1(4'b0, 4'b0010, "os_busy");
    cyc1(4'b0010, 4'b0, "os_tick");
    repeat (2) cyc1(4'b0, 4'b0, "os_idle");
    start = 4'b0010;
    cyc1(4'b0, 4'b0010, "rs_start");
    cyc1(4'b0, 4'b0010, "rs_busy");
    start = 4'b0010;
    cyc1(4'b0, 4'b0010, "rs_restart");
    repeat (3) cyc1(4'b0, 4'b0010, "rs_busy2");
    cyc1(4'b0010, 4'b0, "rs_tick");
    cyc1(4'b0, 4'b0, "rs_idle");
    do_rst();
    en = 4'b0001;
    repeat (2) cyc1(4'b0, 4'b0, "pz_run");
    en = 4'b0000;
    repeat (5) cyc1(4'b0, 4'b0, "pz_hold");
    en = 4'b0001;
    cyc1(4'b0, 4'b0, "pz_resume");
    cyc1(4'b0001, 4'b0, "pz_tick");
    repeat (3) cyc1(4'b0, 4'b0, "pz_cnt");
    cyc1(4'b0001, 4'b0, "pz_tick2");
    do_rst();
    en = 4'b0001;
    repeat (3) cyc1(4'b0, 4'b0, "lt_run");
    load = 1'b1;
    load_ch = 3'd0;
    load_val = 8'd7;
    start = 4'b0001;
    cyc1(4'b0, 4'b0, "lt_collide");
    repeat (7) cyc1(4'b0, 4'b0, "lt_cnt");
    cyc1(4'b0001, 4'b0, "lt_tick");
    do_rst();
    mode = 4'b0010;
    load = 1'b1;
    load_ch = 3'd2;
    load_val = 8'd0;
    cyc1(4'b0, 4'b0, "rr_ld2");
    load = 1'b1;
    load_ch = 3'd0;
    load_val = 8'd7;
    cyc1(4'b0, 4'b0, "rr_ld0");
    en = 4'b0010;
    start = 4'b0010;
    cyc1(4'b0, 4'b0010, "rr_start");
    repeat (2) cyc1(4'b0, 4'b0010, "rr_busy");
    rst = 1'b1;
    cyc1(4'b0, 4'b0, "rr_reset");
    rst = 1'b0;
    mode = 4'b0000;
    en = 4'b1111;
    repeat (2) begin
      repeat (3) cyc1(4'b0, 4'b0, "rr_cnt");
      cyc1(4'b1111, 4'b0, "rr_tick");
    end
    repeat (2) @(posedge dclk);
    #1;
    while (q.size() > 0) begin
      e = q.pop_front();
      ntot++;
      $display("FAIL %s unchecked expected tick=%b busy=%b got none", e.nm, e.t, e.b);
    end
    if (ntot < 12) $display("FAIL too few checks ran: %0d", ntot);
    if (npass != ntot) $display("FAIL %0d checks failed", ntot - npass);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
